seq_multdiv_unit: RTL and testbench

SEQ_MULTDIV_UNIT -- requirements
Module: seq_multdiv_unit

---
 rtl/seq_multdiv_unit_if.sv | 24 ++
 rtl/seq_multdiv_unit.sv | 158 +++++++++++++++
 tb/tb_seq_multdiv_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_multdiv_unit_if.sv
// Operand/control and result bus for the sequential multiply/divide unit.
// The initiator drives operands and start pulses; the unit returns result, flags and status.
interface seq_multdiv_unit_if;
   localparam int unsigned DATA_W = 32;

   logic [DATA_W-1:0] data_operandA;
   logic [DATA_W-1:0] data_operandB;
   logic              ctrl_MULT;
   logic              ctrl_DIV;
   logic [DATA_W-1:0] data_result;
   logic              data_exception;
   logic              data_resultRDY;
   logic              data_busy;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY, data_busy
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY, data_busy
   );
endinterface

// File: rtl/seq_multdiv_unit.sv
// Sequential 32-bit signed multiply (shift-add) / divide (restoring) unit.
// Both operations take 32 iterations on magnitudes; sign and exceptions are applied at completion.
module seq_multdiv_unit (
   input logic               clock,
   input logic               reset,
   seq_multdiv_unit_if.slave bus
);
   localparam int unsigned W    = 32;
   localparam int unsigned PW   = 2 * W;
   localparam int unsigned CW   = 6;
   localparam logic [CW-1:0] LAST = CW'(31);
   localparam logic [W-1:0]  MIN_VAL = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MULT_RUN = 2'd1,
      DIV_RUN  = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  count;
   logic           op_div;
   logic           sign_neg;
   logic           div_zero;
   logic [W:0]     work_hi;
   logic [W-1:0]   work_lo;
   logic [W-1:0]   opd;

   logic [W-1:0]   result_q;
   logic           exc_q;
   logic           rdy_q;
   logic           busy_q;
   logic [W-1:0]   result_nxt;
   logic           exc_nxt;
   logic           rdy_nxt;
   logic           busy_nxt;

   logic           start_c;
   logic [W:0]     add_c;
   logic [W:0]     shl_c;
   logic [W:0]     diff_c;
   logic           fits_c;
   logic [PW-1:0]  prod_c;
   logic [PW-1:0]  sprod_c;
   logic [W-1:0]   squo_c;

   function automatic logic [W-1:0] mag_of(input logic [W-1:0] v);
      return v[W-1] ? (~v + W'(1)) : v;
   endfunction

   assign start_c = bus.ctrl_MULT | bus.ctrl_DIV;

   // Iteration arithmetic: one shift-add step and one restoring-divide step.
   assign add_c   = work_hi + (work_lo[0] ? {1'b0, opd} : (W+1)'(0));
   assign shl_c   = {work_hi[W-1:0], work_lo[W-1]};
   assign diff_c  = shl_c - {1'b0, opd};
   assign fits_c  = (shl_c >= {1'b0, opd});

   assign prod_c  = {work_hi[W-1:0], work_lo};
   assign sprod_c = sign_neg ? (~prod_c + PW'(1)) : prod_c;
   assign squo_c  = sign_neg ? (~work_lo + W'(1)) : work_lo;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a start edge overrides everything, MULT wins over DIV.
   always_comb begin
      state_nxt = state;
      if (start_c) begin
         state_nxt = bus.ctrl_MULT ? MULT_RUN : DIV_RUN;
      end else begin
         case (state)
            MULT_RUN, DIV_RUN: if (count == LAST) state_nxt = DONE;
            DONE:              state_nxt = IDLE;
            default:           state_nxt = state;
         endcase
      end
   end

   // Output logic: busy lags the state by one edge so it spans edges 1..33.
   always_comb begin
      busy_nxt   = (state != IDLE);
      rdy_nxt    = (state == DONE);
      result_nxt = result_q;
      exc_nxt    = exc_q;
      if (state == DONE) begin
         if (!op_div) begin
            result_nxt = sprod_c[W-1:0];
            exc_nxt    = (|sprod_c[PW-1:W-1]) && !(&sprod_c[PW-1:W-1]);
         end else if (div_zero) begin
            result_nxt = '0;
            exc_nxt    = 1'b1;
         end else begin
            result_nxt = squo_c;
            exc_nxt    = !sign_neg && (work_lo == MIN_VAL);
         end
      end
   end

   // Operand capture and iteration datapath
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         op_div   <= 1'b0;
         sign_neg <= 1'b0;
         div_zero <= 1'b0;
         work_hi  <= '0;
         work_lo  <= '0;
         opd      <= '0;
      end else if (start_c) begin
         count    <= '0;
         op_div   <= !bus.ctrl_MULT;
         sign_neg <= bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
         div_zero <= (bus.data_operandB == '0);
         work_hi  <= '0;
         if (bus.ctrl_MULT) begin
            work_lo <= mag_of(bus.data_operandB);
            opd     <= mag_of(bus.data_operandA);
         end else begin
            work_lo <= mag_of(bus.data_operandA);
            opd     <= mag_of(bus.data_operandB);
         end
      end else if (state == MULT_RUN) begin
         count   <= count + CW'(1);
         work_hi <= {1'b0, add_c[W:1]};
         work_lo <= {add_c[0], work_lo[W-1:1]};
      end else if (state == DIV_RUN) begin
         count   <= count + CW'(1);
         work_hi <= fits_c ? diff_c : shl_c;
         work_lo <= {work_lo[W-2:0], fits_c};
      end
   end

   // Registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         result_q <= result_nxt;
         exc_q    <= exc_nxt;
         rdy_q    <= rdy_nxt;
         busy_q   <= busy_nxt;
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;
   assign bus.data_busy      = busy_q;
endmodule

// File: tb/tb_seq_multdiv_unit.sv
// Self-checking bench for seq_multdiv_unit: fixed vectors, corner sequences
// (abort, dual request, mid-operation reset) and randomized ops against an arithmetic model.
module tb_seq_multdiv_unit;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   seq_multdiv_unit_if bus();

   seq_multdiv_unit dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_r;
      logic        exp_e;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Reference: plain 64-bit signed arithmetic.
   task automatic model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e);
      longint sa, sb, p, max_v, min_v;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      max_v = 64'sh0000_0000_7FFF_FFFF;
      min_v = -64'sh0000_0000_8000_0000;
      if (!is_div) begin
         p = sa * sb;
         r = p[31:0];
         e = (p > max_v) || (p < min_v);
      end else if (sb == 0) begin
         r = '0;
         e = 1'b1;
      end else begin
         p = sa / sb;
         r = p[31:0];
         e = (p > max_v);
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'h0000_0000;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h0000_0001;
         4:       v = 32'h7FFF_FFFF;
         5:       v = 32'($urandom_range(0, 200)) - 32'd100;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Issue one start pulse and observe 36 edges; reports first RDY edge, pulse count, busy errors.
   task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output int lat,
                         output int npulse, output int busy_err);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      @(posedge clk); #1;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      lat      = -1;
      npulse   = 0;
      busy_err = (bus.data_busy !== 1'b0) ? 1 : 0;
      r        = '0;
      e        = 1'b0;
      for (int k = 1; k <= 36; k++) begin
         @(posedge clk); #1;
         if (bus.data_resultRDY === 1'b1) begin
            npulse++;
            if (lat < 0) begin
               lat = k;
               r   = bus.data_result;
               e   = bus.data_exception;
            end
         end
         if (bus.data_busy !== (k <= 33)) busy_err++;
      end
      if (bus.data_result !== r || bus.data_exception !== e) busy_err++;
   endtask

   vec_t        vecs[12];
   logic [31:0] r, er, a, b;
   logic        e, ee, m, d;
   int          lat, np, be, pulses;

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;

      vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
      vecs[1]  = '{1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[2]  = '{1'b1, 32'hFFFF_FFD5,  32'd5,         32'hFFFF_FFF8, 1'b0};
      vecs[3]  = '{1'b1, 32'd10,         32'd0,         32'h0000_0000, 1'b1};
      vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[5]  = '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
      vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[7]  = '{1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
      vecs[8]  = '{1'b0, 32'd0,          32'hFFFF_FFFB, 32'h0000_0000, 1'b0};
      vecs[9]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
      vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      vecs[11] = '{1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h0000_0001, 1'b1};

      #2;
      chk("reset_result", 64'(bus.data_result), 64'h0);
      chk("reset_exc",    64'(bus.data_exception), 64'h0);
      chk("reset_rdy",    64'(bus.data_resultRDY), 64'h0);
      chk("reset_busy",   64'(bus.data_busy), 64'h0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         run_op(!vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b, r, e, lat, np, be);
         chk($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].exp_r));
         chk($sformatf("vec%0d_exc", i), 64'(e), 64'(vecs[i].exp_e));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
         chk($sformatf("vec%0d_pulses", i), 64'(np), 64'd1);
         chk($sformatf("vec%0d_busy_hold", i), 64'(be), 64'd0);
      end

      // Both requests together: multiply wins.
      run_op(1'b1, 1'b1, 32'd9, 32'd3, r, e, lat, np, be);
      chk("dual_result", 64'(r), 64'd27);
      chk("dual_exc", 64'(e), 64'd0);
      chk("dual_latency", 64'(lat), 64'd33);

      // Divide aborted by a multiply at edge 10.
      pulses = 0;
      bus.data_operandA = 32'd100;
      bus.data_operandB = 32'd3;
      bus.ctrl_DIV      = 1'b1;
      @(posedge clk); #1;
      bus.ctrl_DIV = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         if (bus.data_resultRDY === 1'b1) pulses++;
      end
      run_op(1'b1, 1'b0, 32'd3, 32'd4, r, e, lat, np, be);
      chk("abort_early_pulses", 64'(pulses), 64'd0);
      chk("abort_result", 64'(r), 64'd12);
      chk("abort_exc", 64'(e), 64'd0);
      chk("abort_latency", 64'(lat), 64'd33);
      chk("abort_pulses", 64'(np), 64'd1);

      // Reset at edge 20 of a multiply.
      pulses = 0;
      bus.data_operandA = 32'd5;
      bus.data_operandB = 32'd6;
      bus.ctrl_MULT     = 1'b1;
      @(posedge clk); #1;
      bus.ctrl_MULT = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus.data_resultRDY === 1'b1) pulses++;
      end
      rst_n = 1'b0;
      #1;
      chk("rst_mid_result", 64'(bus.data_result), 64'h0);
      chk("rst_mid_busy", 64'(bus.data_busy), 64'h0);
      chk("rst_mid_exc", 64'(bus.data_exception), 64'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (bus.data_resultRDY === 1'b1) pulses++;
      end
      rst_n = 1'b1;
      run_op(1'b0, 1'b1, 32'd9, 32'd3, r, e, lat, np, be);
      chk("rst_no_pulse", 64'(pulses), 64'd0);
      chk("rst_div_result", 64'(r), 64'd3);
      chk("rst_div_latency", 64'(lat), 64'd33);
      chk("rst_div_pulses", 64'(np), 64'd1);

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         a = pick();
         b = pick();
         m = 1'($urandom_range(0, 1));
         d = (!m) ? 1'b1 : 1'($urandom_range(0, 1));
         model(!m, a, b, er, ee);
         run_op(m, d, a, b, r, e, lat, np, be);
         chk($sformatf("rnd%0d_%s_%h_%h_result", i, m ? "mul" : "div", a, b), 64'(r), 64'(er));
         chk($sformatf("rnd%0d_exc", i), 64'(e), 64'(ee));
         chk($sformatf("rnd%0d_timing", i), {32'(lat), 32'(np)}, {32'd33, 32'd1});
         chk($sformatf("rnd%0d_busy", i), 64'(be), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
